// File: rtl/hs_initiator_pkg.sv
// Shared FSM encodings, parameter defaults and sizing helper for hs_initiator.
package hs_initiator_pkg;

    typedef enum logic [2:0] {
        HsIdle  = 3'd0,
        HsFetch = 3'd1,
        HsLoad  = 3'd2,
        HsSend  = 3'd3,
        HsDone  = 3'd4
    } hs_state_e;

    localparam int unsigned HsWidthDefault   = 8;
    localparam int unsigned HsLenWDefault    = 8;
    localparam int unsigned HsTimeoutDefault = 255;

    // Counter width able to hold 0 .. limit-1.
    function automatic int unsigned hs_cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/hs_initiator_if.sv
// Source-FIFO read port plus downstream valid/ready channel of hs_initiator.
interface hs_initiator_if import hs_initiator_pkg::*; #(
    parameter int unsigned WIDTH = HsWidthDefault
);
    logic             src_empty;
    logic             src_rd;
    logic [WIDTH-1:0] src_data;
    logic             init_valid;
    logic             init_ready;
    logic [WIDTH-1:0] init_data;

    modport master (
        input  src_empty, src_data, init_ready,
        output src_rd, init_valid, init_data
    );

    modport slave (
        output src_empty, src_data, init_ready,
        input  src_rd, init_valid, init_data
    );
endinterface

// File: rtl/hs_stall_wdt.sv
// Consecutive-stall counter; expire_o flags the last allowed stalled cycle.
module hs_stall_wdt import hs_initiator_pkg::*; #(
    parameter int unsigned TIMEOUT = HsTimeoutDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    output logic expire_o
);
    localparam int unsigned CntW = hs_cnt_width(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = stall_i && (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (stall_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/hs_initiator.sv
// Burst transmitter: reads a latency-1 source FIFO and sends burst_len beats on valid/ready.
// Optional stall watchdog and timeout port enabled by defining HS_TIMEOUT_EN.
module hs_initiator import hs_initiator_pkg::*; #(
    parameter int unsigned WIDTH   = HsWidthDefault,
    parameter int unsigned LEN_W   = HsLenWDefault,
    parameter int unsigned TIMEOUT = HsTimeoutDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] beat_cnt,
`ifdef HS_TIMEOUT_EN
    output logic             timeout,
`endif
    hs_initiator_if.master   bus
);
    hs_state_e        state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             src_rd;
    logic             xfer;
    logic             expire;

    // valid_q is only ever set in SEND, so a handshake implies SEND.
    assign xfer = valid_q && bus.init_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        src_rd      = 1'b0;
        unique case (state_q)
            HsIdle: begin
                if (start && (burst_len != '0)) begin
                    state_d     = HsFetch;
                    remaining_d = burst_len;
                    beat_cnt_d  = '0;
                end
            end
            HsFetch: begin
                if (!bus.src_empty) begin
                    src_rd  = 1'b1;
                    state_d = HsLoad;
                end
            end
            HsLoad: begin
                data_d  = bus.src_data;
                valid_d = 1'b1;
                state_d = HsSend;
            end
            HsSend: begin
                if (xfer) begin
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    valid_d     = 1'b0;
                    state_d     = (remaining_q == LEN_W'(1)) ? HsDone : HsFetch;
                end else if (expire) begin
                    valid_d = 1'b0;
                    state_d = HsIdle;
                end
            end
            HsDone: begin
                state_d = HsIdle;
            end
            default: begin
                state_d = HsIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HsIdle;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

`ifdef HS_TIMEOUT_EN
    logic timeout_q;

    hs_stall_wdt #(
        .TIMEOUT(TIMEOUT)
    ) u_stall_wdt (
        .clk     (clk),
        .rst     (rst),
        .stall_i ((state_q == HsSend) && !bus.init_ready),
        .expire_o(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout;
    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign busy           = (state_q != HsIdle);
    assign done           = (state_q == HsDone);
    assign beat_cnt       = beat_cnt_q;
    assign bus.src_rd     = src_rd;
    assign bus.init_valid = valid_q;
    assign bus.init_data  = data_q;
endmodule
